// File: rtl/tdm_demux_if.sv
// Bundle between a TDM link and tdm_demux: the multiplexed sample stream in,
// the per-channel held samples and alignment status out.
interface tdm_demux_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [DATA_W-1:0]        din;
    logic                     din_valid;
    logic                     frame_sync;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [CH_W-1:0]          cur_ch;
    logic                     locked;
    logic                     frame_done;
    logic                     sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_data, ch_valid, cur_ch, locked, frame_done, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch_data, ch_valid, cur_ch, locked, frame_done, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes each sample of a frame-sync-marked stream to its own
// channel register. Define TDM_DEMUX_FRAME_LATCH_EN to publish whole frames at once.
module tdm_demux_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_i,
    input  logic              pub_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] q_q;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    logic [DATA_W-1:0] shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        shadow_q <= '0;
        else if (cap_i) shadow_q <= d_i;
        else if (clr_i) shadow_q <= '0;
    end

    // The lane that closes the frame publishes its sample directly from d_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q_q <= '0;
        else if (pub_i) q_q <= cap_i ? d_i : shadow_q;
    end
`else
    logic unused_ok;
    assign unused_ok = pub_i ^ clr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q_q <= '0;
        else if (cap_i) q_q <= d_i;
    end
`endif

    assign q_o = q_q;
endmodule

module tdm_demux #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
) (
    input logic        clk,
    input logic        rst,
    tdm_demux_if.slave bus
);
    localparam int              CH_W    = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [0:0]      HUNT    = 1'b0;
    localparam logic [0:0]      LOCKED  = 1'b1;

    logic [0:0]                    state_q, state_d;
    logic [CH_W-1:0]               cur_ch_q, cur_ch_d;
    logic                          aligned_q, aligned_d;
    logic [NUM_CH-1:0]             ch_valid_q, ch_valid_d;
    logic                          frame_done_q, frame_done_d;
    logic                          sync_err_q, sync_err_d;
    logic [NUM_CH-1:0]             cap;
    logic [NUM_CH-1:0][DATA_W-1:0] lane_q;

    // aligned_q marks a frame opened by a sync at the expected slot; a frame
    // opened by a resync is captured but never reported complete.
    always_comb begin
        state_d      = state_q;
        cur_ch_d     = cur_ch_q;
        aligned_d    = aligned_q;
        cap          = '0;
        sync_err_d   = 1'b0;
        frame_done_d = 1'b0;
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        cap[0]    = 1'b1;
                        cur_ch_d  = CH_W'(1);
                        aligned_d = 1'b1;
                        state_d   = LOCKED;
                    end
                end
                default: begin
                    if (bus.frame_sync) begin
                        cap[0]     = 1'b1;
                        cur_ch_d   = CH_W'(1);
                        sync_err_d = (cur_ch_q != '0);
                        aligned_d  = (cur_ch_q == '0);
                    end else if (cur_ch_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        cap[cur_ch_q] = 1'b1;
                        if (cur_ch_q == LAST_CH) begin
                            cur_ch_d     = '0;
                            frame_done_d = aligned_q;
                        end else begin
                            cur_ch_d = cur_ch_q + CH_W'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    assign ch_valid_d = {NUM_CH{frame_done_d}};
`else
    assign ch_valid_d = cap;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            cur_ch_q     <= '0;
            aligned_q    <= 1'b0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_ch_q     <= cur_ch_d;
            aligned_q    <= aligned_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        tdm_demux_lane #(.DATA_W(DATA_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .cap_i (cap[i]),
            .pub_i (frame_done_d),
            .clr_i (sync_err_d),
            .d_i   (bus.din),
            .q_o   (lane_q[i])
        );
    end

    assign bus.ch_data    = lane_q;
    assign bus.ch_valid   = ch_valid_q;
    assign bus.cur_ch     = cur_ch_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed test-plan sequences with literal expectations, then
// random traffic checked every cycle against a frame-queue model of the link.
module tb_tdm_demux;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 8;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();
    tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nvec = 0;
    int nerr = 0;
    bit run  = 1'b0;

    // Model: samples of the frame in progress, lock flag, and whether the frame
    // was opened by a sync at the expected slot.
    logic [DATA_W-1:0]        fq[$];
    bit                       m_lock, m_algn;
    logic [NUM_CH*DATA_W-1:0] exp_data;
    logic [NUM_CH-1:0]        exp_valid;
    logic                     exp_done, exp_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void accept(input logic [DATA_W-1:0] d);
        int idx = fq.size();
        fq.push_back(d);
        if (!LATCH) begin
            exp_data[idx*DATA_W +: DATA_W] = d;
            exp_valid[idx] = 1'b1;
        end
        if (fq.size() == NUM_CH) begin
            if (m_algn) begin
                exp_done = 1'b1;
                if (LATCH) begin
                    for (int i = 0; i < NUM_CH; i++) exp_data[i*DATA_W +: DATA_W] = fq[i];
                    exp_valid = '1;
                end
            end
            fq.delete();
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            m_lock = 1'b0; m_algn = 1'b0;
            exp_data = '0; exp_valid = '0; exp_done = 1'b0; exp_err = 1'b0;
        end else begin
            exp_valid = '0; exp_done = 1'b0; exp_err = 1'b0;
            if (bus.din_valid) begin
                if (bus.frame_sync) begin
                    exp_err = m_lock && (fq.size() != 0);
                    m_algn  = !exp_err;
                    m_lock  = 1'b1;
                    fq.delete();
                    accept(bus.din);
                end else if (m_lock && fq.size() == 0) begin
                    exp_err = 1'b1;
                    m_lock  = 1'b0;
                end else if (m_lock) begin
                    accept(bus.din);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("ch_data",    bus.ch_data,    exp_data);
            chk("ch_valid",   bus.ch_valid,   exp_valid);
            chk("cur_ch",     bus.cur_ch,     fq.size());
            chk("locked",     bus.locked,     m_lock);
            chk("frame_done", bus.frame_done, exp_done);
            chk("sync_err",   bus.sync_err,   exp_err);
        end
    end

    task automatic drv(input logic v, input logic fs, input logic [DATA_W-1:0] d);
        bus.din_valid  = v;
        bus.frame_sync = fs;
        bus.din        = d;
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        bus.din_valid = 1'b0; bus.frame_sync = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.din = '0; bus.din_valid = 1'b0; bus.frame_sync = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        chk("rst_data",   bus.ch_data, 16'h0000);
        chk("rst_locked", bus.locked, 1'b0);
        chk("rst_cur",    bus.cur_ch, 1'b0);
        #2 rst = 1'b0;
        @(negedge clk);

        // 1: basic alignment
        drv(1, 1, 8'h11);
        chk("t1_d0",     bus.ch_data[7:0], LATCH ? 8'h00 : 8'h11);
        chk("t1_v0",     bus.ch_valid, LATCH ? 2'b00 : 2'b01);
        drv(1, 0, 8'h22);
        chk("t1_data",   bus.ch_data, 16'h2211);
        chk("t1_v1",     bus.ch_valid, LATCH ? 2'b11 : 2'b10);
        chk("t1_done",   bus.frame_done, 1'b1);
        chk("t1_locked", bus.locked, 1'b1);
        chk("t1_cur",    bus.cur_ch, 1'b0);

        // 2: hunt discard
        rst_pulse();
        drv(1, 0, 8'hAA);
        drv(1, 0, 8'hBB);
        chk("t2_v",      bus.ch_valid, 2'b00);
        chk("t2_err",    bus.sync_err, 1'b0);
        chk("t2_unlock", bus.locked, 1'b0);
        drv(1, 1, 8'h33);
        chk("t2_d0",     bus.ch_data[7:0], LATCH ? 8'h00 : 8'h33);
        chk("t2_locked", bus.locked, 1'b1);
        drv(1, 0, 8'h34);

        // 3: bubbles
        drv(1, 1, 8'h01);
        repeat (3) begin
            drv(0, 1, 8'hEE);
            chk("t3_cur", bus.cur_ch, 1'b1);
        end
        drv(1, 0, 8'h02);
        chk("t3_data", bus.ch_data, 16'h0201);
        chk("t3_done", bus.frame_done, 1'b1);

        // 4: early sync
        drv(1, 1, 8'h10);
        drv(1, 1, 8'h20);
        chk("t4_err",  bus.sync_err, 1'b1);
        chk("t4_done", bus.frame_done, 1'b0);
        chk("t4_cur",  bus.cur_ch, 1'b1);
        chk("t4_d0",   bus.ch_data[7:0], LATCH ? 8'h01 : 8'h20);
        drv(1, 0, 8'h21);

        // 5: missing sync
        drv(1, 1, 8'h10);
        drv(1, 0, 8'h20);
        chk("t5_done",   bus.frame_done, 1'b1);
        drv(1, 0, 8'h30);
        chk("t5_err",    bus.sync_err, 1'b1);
        chk("t5_locked", bus.locked, 1'b0);
        chk("t5_data",   bus.ch_data, 16'h2010);

        // 6: asynchronous reset between channel 0 and channel 1
        drv(1, 1, 8'h55);
        bus.din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_data",   bus.ch_data, 16'h0000);
        chk("t6_valid",  bus.ch_valid, 2'b00);
        chk("t6_locked", bus.locked, 1'b0);
        chk("t6_cur",    bus.cur_ch, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        drv(1, 0, 8'h66);
        chk("t6_hunt", bus.locked, 1'b0);
        drv(1, 1, 8'h77);
        chk("t6_relock", bus.locked, 1'b1);

        // random traffic, mostly well-formed frames with occasional sync faults
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_pulse();
            end else begin
                logic v, fs;
                v  = ($urandom_range(0, 3) != 0);
                fs = (fq.size() == 0) ? ($urandom_range(0, 19) != 0)
                                      : ($urandom_range(0, 19) == 0);
                drv(v, fs, 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart to the 2:1 mux: takes a time-division-multiplexed sample stream and routes each sample to its own per-channel output register.
- Tracks the slot position with a channel counter locked to a frame-sync marker.
- Flags sync loss and re-acquires alignment automatically.
- Sits at the far end of a mux-driven TDM link, so channel i of the transmitter reappears on output i.

Parameters:
- NUM_CH, 2, number of TDM channels per frame; legal range is 2 or more.
- DATA_W, 8, width of one sample in bits.
- CH_W, $clog2(NUM_CH), width of the channel index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  DATA_W  incoming multiplexed sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current sample as channel 0.
- ch_data  output  NUM_CH*DATA_W  per-channel held samples; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_valid  output  NUM_CH  one-cycle strobe per channel when its ch_data slice updates.
- cur_ch  output  CH_W  channel index the next valid sample will be written to.
- locked  output  1  high in state LOCKED.
- frame_done  output  1  one-cycle pulse when the last channel (NUM_CH-1) of a frame is published.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (async assert, takes effect immediately):
  - ch_data = 0, ch_valid = 0, cur_ch = 0, locked = 0, frame_done = 0, sync_err = 0.
  - State = HUNT; shadow registers (if present) = 0.
- Cycles with din_valid = 0: no state change; frame_sync is ignored; all strobes are 0.
- HUNT:
  - Valid samples without frame_sync are discarded; no strobe, no error.
  - Valid sample with frame_sync: capture as channel 0; cur_ch = 1; go to LOCKED.
- LOCKED:
  - Valid sample without frame_sync and cur_ch != 0: capture into channel cur_ch; cur_ch increments.
  - cur_ch wraps from NUM_CH-1 to 0.
- Resync violation (LOCKED, frame_sync with cur_ch != 0):
  - Pulse sync_err.
  - Treat the sample as channel 0 (capture it); cur_ch = 1; remain LOCKED.
  - The partial frame is never reported by frame_done.
- Missing-sync violation (LOCKED, cur_ch == 0, valid sample without frame_sync):
  - Pulse sync_err; discard the sample; go to HUNT; locked falls next cycle.
- Expected sync (LOCKED, cur_ch == 0, frame_sync present): normal channel-0 capture.
- Latency and strobes:
  - A sample accepted at edge N appears on ch_data with its ch_valid bit high during the cycle after edge N.
  - Each strobe lasts exactly 1 cycle.
  - At most one ch_valid bit is set per cycle unless the frame-latch feature is enabled.
  - frame_done is coincident with the ch_valid of channel NUM_CH-1, only when that frame began with a properly aligned channel 0.
- Data holding: ch_data slices not being updated keep their previous value; no clearing on sync_err.
- Reset asserted mid-frame: everything returns to reset values; the first post-reset sample requires frame_sync.

Optional Feature:
- Macro: TDM_DEMUX_FRAME_LATCH_EN.
- Without the macro: behaviour as above; each channel slice updates individually one cycle after its sample.
- With the macro:
  - Samples are captured into internal shadow registers.
  - ch_data updates only when channel NUM_CH-1 of an aligned frame is captured: all slices update together one cycle later, all ch_valid bits are set simultaneously for 1 cycle, and frame_done pulses with them.
  - On sync_err, shadow contents of the partial frame are discarded; ch_data is unchanged.
  - Ports, reset values and the state machine are identical in both builds.

Test Plan (NUM_CH=2, DATA_W=8):
1. Basic alignment:
   - Stimulus: after reset, valid 0x11 with frame_sync, then valid 0x22.
   - Response: ch_data[7:0] = 0x11 with ch_valid = 01, next cycle ch_data[15:8] = 0x22 with ch_valid = 10 and frame_done = 1; locked = 1; cur_ch = 0.
2. Hunt discard:
   - Stimulus: valid 0xAA and 0xBB with no frame_sync, then 0x33 with frame_sync.
   - Response: no strobes or sync_err for 0xAA/0xBB; 0x33 lands in channel 0; locked rises.
3. Bubbles:
   - Stimulus: aligned frame 0x01, idle 3 cycles, then 0x02.
   - Response: cur_ch holds at 1 through the idle cycles; 0x02 goes to channel 1; frame_done = 1.
4. Early sync:
   - Stimulus: 0x10 with frame_sync, then 0x20 with frame_sync.
   - Response: sync_err pulses; 0x20 goes to channel 0; no frame_done; cur_ch = 1.
5. Missing sync:
   - Stimulus: full frame 0x10/0x20, then 0x30 without frame_sync.
   - Response: sync_err pulses; 0x30 is dropped; locked = 0; ch_data is unchanged.
6. Async reset mid-frame:
   - Stimulus: assert rst between the channel-0 and channel-1 samples.
   - Response: all outputs are 0 immediately, without waiting for a clock edge; state = HUNT.
   - Repeat test 1 with the macro defined: both slices update in the same cycle, ch_valid = 11, frame_done = 1.
